// File: rtl/nios_oci_dct_packer_if.sv
// Trace-atom input and DCT frame output bundle for the OCI DCT packer.
// The master side is the packer. The slave side is the atom source together with the frame sink.
interface nios_oci_dct_packer_if #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4
);
  localparam int BUF_W = ATOM_W * ATOMS;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom_code;
  logic              atom_ready;
  logic              test_ending;
  logic              frame_valid;
  logic              frame_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_has_ended;

  modport master (
    input  atom_valid, atom_code, test_ending, frame_ready,
    output atom_ready, frame_valid, dct_buffer, dct_count, test_has_ended
  );

  modport slave (
    output atom_valid, atom_code, test_ending, frame_ready,
    input  atom_ready, frame_valid, dct_buffer, dct_count, test_has_ended
  );
endinterface

// File: rtl/nios_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames (first atom in the top pair) behind a
// one-deep output register. On test_ending it flushes any partial frame and then reports completion.
module nios_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_oci_dct_packer_if.master bus
);
  localparam int BUF_W = ATOM_W * ATOMS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ATOMS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

  typedef enum logic [1:0] {FILL, FLUSH, ENDED} state_t;

  state_t           state, state_nxt;
  logic [BUF_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_nxt;
  logic [BUF_W-1:0] out_buf, out_buf_nxt;
  logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
  logic             out_vld, out_vld_nxt;

  logic slot_free;
  logic accept;
  logic take;

  assign slot_free = !out_vld || bus.frame_ready;
  assign take      = out_vld && bus.frame_ready;
  // The 15th atom may only enter once the output register can take the completed frame.
  assign bus.atom_ready = (state == FILL) && ((acc_cnt != CNT_LAST) || slot_free);
  assign accept    = bus.atom_valid && bus.atom_ready;

  assign bus.frame_valid    = out_vld;
  assign bus.dct_buffer     = out_buf;
  assign bus.dct_count      = out_cnt;
  assign bus.test_has_ended = (state == ENDED);

  // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    acc_cnt_nxt = acc_cnt;
    out_buf_nxt = out_buf;
    out_cnt_nxt = out_cnt;
    out_vld_nxt = out_vld;

    if (take) out_vld_nxt = 1'b0;

    unique case (state)
      FILL: begin
        if (accept) begin
          if (acc_cnt == CNT_LAST) begin
            out_buf_nxt = {acc[BUF_W-ATOM_W-1:0], bus.atom_code};
            out_cnt_nxt = CNT_FULL;
            out_vld_nxt = 1'b1;
            acc_nxt     = '0;
            acc_cnt_nxt = '0;
          end else begin
            acc_nxt     = {acc[BUF_W-ATOM_W-1:0], bus.atom_code};
            acc_cnt_nxt = acc_cnt + 1'b1;
          end
        end
        if (bus.test_ending) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Completion is judged on the current registers, so the edge that takes the last frame is not yet ENDED.
        if ((acc_cnt != '0) && slot_free) begin
          out_buf_nxt = acc;
          out_cnt_nxt = acc_cnt;
          out_vld_nxt = 1'b1;
          acc_nxt     = '0;
          acc_cnt_nxt = '0;
        end else if ((acc_cnt == '0) && !out_vld) begin
          state_nxt = ENDED;
        end
      end
      ENDED: ;
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      acc     <= '0;
      acc_cnt <= '0;
      out_buf <= '0;
      out_cnt <= '0;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      acc_cnt <= acc_cnt_nxt;
      out_buf <= out_buf_nxt;
      out_cnt <= out_cnt_nxt;
      out_vld <= out_vld_nxt;
    end
  end
endmodule
